btn_input_ctrl: RTL



---
 rtl/input_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 58 +++++
 rtl/btn_input_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/input_pkg.sv
// ---------------------------------------------------------------------------
// input_pkg
// Shared definitions for the player-input front end.
//   jump_state_t    : jump FSM states (IDLE, CHARGE, RELEASE, COOLDOWN)
//   DEFAULT_*       : default parameter values used by btn_input_ctrl and
//                     btn_debounce
//   DEB_CNT_W       : width of the per-button debounce counter
//   cooldown_width  : width needed to hold a cooldown tick count
// ---------------------------------------------------------------------------
package input_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHARGE   = 2'd1,
        RELEASE  = 2'd2,
        COOLDOWN = 2'd3
    } jump_state_t;

    localparam int DEFAULT_SYNC_STAGES    = 2;
    localparam int DEFAULT_DEBOUNCE_N     = 4;
    localparam int DEFAULT_CHARGE_W       = 6;
    localparam int DEFAULT_CHARGE_MAX     = 63;
    localparam int DEFAULT_COOLDOWN_TICKS = 8;

    // Debounce counter is fixed at 4 bits, which covers DEBOUNCE_N up to 15.
    localparam int DEB_CNT_W = 4;

    // A zero or one tick cooldown still needs a one-bit counter.
    function automatic int cooldown_width(input int ticks);
        return (ticks < 2) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchroniser plus sample-strobed debouncer for one raw board button.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sample_en  in   one-cycle strobe; the debounce counter only moves on it
//   raw        in   unsynchronised button pin
//   deb        out  debounced button level
// ---------------------------------------------------------------------------
module btn_debounce
    import input_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_N  = DEFAULT_DEBOUNCE_N
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic raw,
    output logic deb
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [DEB_CNT_W-1:0]   cnt;

    assign synced = sync[SYNC_STAGES-1];

    // The synchroniser runs every clock so metastability settling does not
    // depend on how often the sample strobe fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Any sample that agrees with the current level restarts the count, so
    // only DEBOUNCE_N consecutive disagreeing samples can flip the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sample_en) begin
            if (synced == deb) begin
                cnt <= '0;
            end else if (cnt == DEB_CNT_W'(DEBOUNCE_N - 1)) begin
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_input_ctrl.sv
// ---------------------------------------------------------------------------
// btn_input_ctrl
// Player-input front end: debounces the three board buttons, arbitrates
// left/right and runs the hold-to-charge jump FSM.
// Ports:
//   sys_clk            in   system clock
//   sys_rst_n          in   asynchronous active-low reset
//   sample_en          in   sampling strobe shared with the character block
//   raw_left/right/jump in  unsynchronised button pins
//   left_btn           out  debounced left level, suppressed while charging
//   right_btn          out  debounced right level, suppressed while charging
//   jump_btn           out  high while the jump is charging
//   jump_charge        out  live charge count
//   jump_release       out  one-clock pulse when a charged jump is released
//   jump_charge_final  out  charge captured at release, held until the next
// ---------------------------------------------------------------------------
module btn_input_ctrl
    import input_pkg::*;
#(
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_N     = DEFAULT_DEBOUNCE_N,
    parameter int CHARGE_W       = DEFAULT_CHARGE_W,
    parameter int CHARGE_MAX     = DEFAULT_CHARGE_MAX,
    parameter int COOLDOWN_TICKS = DEFAULT_COOLDOWN_TICKS
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                sample_en,
    input  logic                raw_left,
    input  logic                raw_right,
    input  logic                raw_jump,
    output logic                left_btn,
    output logic                right_btn,
    output logic                jump_btn,
    output logic [CHARGE_W-1:0] jump_charge,
    output logic                jump_release,
    output logic [CHARGE_W-1:0] jump_charge_final
);

    localparam int COOL_W = cooldown_width(COOLDOWN_TICKS);

    logic        deb_left;
    logic        deb_right;
    logic        deb_jump;
    jump_state_t state_q;
    jump_state_t state_d;
    logic [COOL_W-1:0] cool_cnt;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_N(DEBOUNCE_N)) u_deb_left (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .sample_en (sample_en),
        .raw       (raw_left),
        .deb       (deb_left)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_N(DEBOUNCE_N)) u_deb_right (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .sample_en (sample_en),
        .raw       (raw_right),
        .deb       (deb_right)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_N(DEBOUNCE_N)) u_deb_jump (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .sample_en (sample_en),
        .raw       (raw_jump),
        .deb       (deb_jump)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RELEASE lasts exactly one clock regardless of the strobe; a zero-tick
    // cooldown skips straight back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sample_en && deb_jump) state_d = CHARGE;
            end
            CHARGE: begin
                if (sample_en && !deb_jump) state_d = RELEASE;
            end
            RELEASE: begin
                state_d = (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;
            end
            COOLDOWN: begin
                if (sample_en && (cool_cnt <= COOL_W'(1))) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Charge starts at 1 on the press tick and saturates at CHARGE_MAX. The
    // final value is captured while in RELEASE, where the live charge is
    // frozen, and the live charge is cleared on the way out.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            jump_charge       <= '0;
            jump_charge_final <= '0;
            cool_cnt          <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sample_en && deb_jump) jump_charge <= CHARGE_W'(1);
                end
                CHARGE: begin
                    if (sample_en && deb_jump && (jump_charge < CHARGE_W'(CHARGE_MAX))) begin
                        jump_charge <= jump_charge + 1'b1;
                    end
                end
                RELEASE: begin
                    jump_charge_final <= jump_charge;
                    jump_charge       <= '0;
                    cool_cnt          <= COOL_W'(COOLDOWN_TICKS);
                end
                COOLDOWN: begin
                    if (sample_en && (cool_cnt != '0)) cool_cnt <= cool_cnt - 1'b1;
                end
                default: begin
                    jump_charge <= '0;
                end
            endcase
        end
    end

    // Horizontal motion is blocked while charging, and opposing directions
    // cancel each other out.
    always_comb begin
        jump_btn     = (state_q == CHARGE);
        jump_release = (state_q == RELEASE);
        left_btn     = deb_left & ~deb_right & (state_q != CHARGE);
        right_btn    = deb_right & ~deb_left & (state_q != CHARGE);
    end

endmodule
